// File: rtl/pipe_pkg.sv
// pipe_pkg: types and constants shared by the fetch stage and the stage downstream of it.
package pipe_pkg;
    localparam int DATA_W = 19;
    typedef enum logic {IDLE, RUN} fetch_state_t;
    typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry data+pc holding register with a full flag.
// Ports: clr_i empties the entry (highest priority), load_i captures data_i/pc_i
// and sets full, unload_i empties the entry. A load in the same cycle as an
// unload replaces the entry. data_o/pc_o/full_o expose the stored entry.
module fetch_skid_buf #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic              unload_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic [DATA_W-1:0] data_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              full_o
);
    logic              full_q, full_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    always_comb begin
        full_d = clr_i ? 1'b0 : load_i ? 1'b1 : unload_i ? 1'b0 : full_q;
        data_d = load_i ? data_i : data_q;
        pc_d   = load_i ? pc_i : pc_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
            pc_q   <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
            pc_q   <= pc_d;
        end
    end
    assign data_o = data_q;
    assign pc_o   = pc_q;
    assign full_o = full_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC-driven fetch from a 1-cycle synchronous memory with a 1-entry skid and redirect squash.
// Ports: en gates new requests; stall holds a valid output; redirect_valid/redirect_pc
// reload the PC and squash everything in flight or buffered; imem_req/imem_addr/imem_rdata
// form the memory read port; out_data/out_pc/valid_out feed the downstream stage.
// Optional macro FETCH_PERF_EN adds saturating perf_fetched/perf_stalls counters.
module fetch_stage
    import pipe_pkg::*;
#(
    parameter int              ADDR_W   = 16,
    parameter int              DATA_W   = pipe_pkg::DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_pc,
    output logic              valid_out
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stalls
`endif
);
    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, ipc_q, ipc_d, opc_q, opc_d, skid_pc;
    logic [DATA_W-1:0] odata_q, odata_d, skid_data;
    logic              inflight_q, inflight_d, valid_q, valid_d;
    logic              out_free, resp, skid_full, skid_load, skid_unload;

    assign out_free    = ~stall | ~valid_q;
    assign resp        = inflight_q & ~redirect_valid;
    // Blocking on a stalled output with a word in flight keeps the skid from overflowing.
    assign imem_req    = (state_q == RUN) & en & ~redirect_valid & ~skid_full
                       & ~(stall & valid_q & inflight_q);
    assign imem_addr   = pc_q;
    assign skid_unload = out_free & skid_full;
    // The skid takes the response whenever it cannot go straight to the output,
    // including when the output is being refilled from the skid (keeps order).
    assign skid_load   = resp & (~out_free | skid_full);

    fetch_skid_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_skid (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (redirect_valid),
        .load_i   (skid_load),
        .unload_i (skid_unload),
        .data_i   (imem_rdata),
        .pc_i     (ipc_q),
        .data_o   (skid_data),
        .pc_o     (skid_pc),
        .full_o   (skid_full)
    );

    always_comb begin
        state_d    = (state_q == IDLE) ? (en ? RUN : IDLE) : (en ? RUN : IDLE);
        pc_d       = redirect_valid ? redirect_pc : imem_req ? pc_q + 1'b1 : pc_q;
        inflight_d = imem_req;
        ipc_d      = imem_req ? pc_q : ipc_q;
        valid_d    = redirect_valid ? 1'b0 : out_free ? (skid_full | resp) : valid_q;
        odata_d    = odata_q;
        opc_d      = opc_q;
        if (~redirect_valid & out_free & skid_full) begin
            odata_d = skid_data;
            opc_d   = skid_pc;
        end else if (out_free & resp) begin
            odata_d = imem_rdata;
            opc_d   = ipc_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            ipc_q      <= '0;
            inflight_q <= 1'b0;
            valid_q    <= 1'b0;
            odata_q    <= '0;
            opc_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ipc_q      <= ipc_d;
            inflight_q <= inflight_d;
            valid_q    <= valid_d;
            odata_q    <= odata_d;
            opc_q      <= opc_d;
        end
    end

    assign out_data  = odata_q;
    assign out_pc    = opc_q;
    assign valid_out = valid_q;

`ifdef FETCH_PERF_EN
    logic [31:0] fetched_q, fetched_d, stalls_q, stalls_d;
    always_comb begin
        fetched_d = fetched_q + {31'b0, valid_q & ~stall & ~&fetched_q};
        stalls_d  = stalls_q + {31'b0, valid_q & stall & ~&stalls_q};
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetched_q <= '0;
            stalls_q  <= '0;
        end else begin
            fetched_q <= fetched_d;
            stalls_q  <= stalls_d;
        end
    end
    assign perf_fetched = fetched_q;
    assign perf_stalls  = stalls_q;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: vector table, directed corner sequences and a word scoreboard for fetch_stage.
module tb_fetch_stage;
    import pipe_pkg::*;
    localparam int AW = 16;

    logic          clk = 1'b0, rst = 1'b1, en = 1'b0, stall = 1'b0, redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          imem_req, valid_out;
    logic [AW-1:0] imem_addr, out_pc;
    word_t         imem_rdata = '0, out_data;
`ifdef FETCH_PERF_EN
    logic [31:0]   perf_fetched, perf_stalls;
`endif

    fetch_stage #(.ADDR_W(AW), .DATA_W(DATA_W), .RESET_PC(16'h0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .out_data       (out_data),
        .out_pc         (out_pc),
        .valid_out      (valid_out)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stalls    (perf_stalls)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (imem_req) imem_rdata <= word_t'(imem_addr) + word_t'(19'h100);

    typedef struct {
        logic          en, st, rd;
        logic [AW-1:0] rpc;
        logic          req;
        logic [AW-1:0] addr;
        logic          v;
        word_t         d;
        logic [AW-1:0] p;
    } vec_t;
    typedef struct {
        word_t         d;
        logic [AW-1:0] p;
    } exp_t;

    vec_t          tv[16];
    exp_t          sb[$];
    int            errors = 0, checks = 0;
    logic [AW-1:0] exp_pc = '0;
    logic          hold_q = 1'b0;
    word_t         hold_d;
    logic [AW-1:0] hold_p;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: inputs already driven; sample 2 units after the falling edge, then
    // run the scoreboard/hold monitor and wait for the next falling edge.
    task automatic cyc();
        exp_t e;
        #2;
        if (rst) begin
            chk("req_in_rst", {31'b0, imem_req}, 32'd0);
            sb.delete();
            exp_pc = '0;
            hold_q = 1'b0;
        end else begin
            if (hold_q) begin
                chk("hold_valid", {31'b0, valid_out}, 32'd1);
                chk("hold_data", 32'(out_data), 32'(hold_d));
                chk("hold_pc", 32'(out_pc), 32'(hold_p));
            end
            if (valid_out && !stall) begin
                if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
                else begin
                    e = sb.pop_front();
                    chk("sb_data", 32'(out_data), 32'(e.d));
                    chk("sb_pc", 32'(out_pc), 32'(e.p));
                end
            end
            if (redirect_valid) begin
                sb.delete();
                exp_pc = redirect_pc;
                chk("req_on_redirect", {31'b0, imem_req}, 32'd0);
            end else if (imem_req) begin
                chk("imem_addr", 32'(imem_addr), 32'(exp_pc));
                sb.push_back('{word_t'(exp_pc) + word_t'(19'h100), exp_pc});
                exp_pc++;
            end
            hold_q = valid_out && stall && !redirect_valid;
            hold_d = out_data;
            hold_p = out_pc;
        end
        @(negedge clk);
    endtask

    task automatic see(input string n, input logic q, input logic [AW-1:0] a, input logic v,
                       input word_t d, input logic [AW-1:0] p, input bit chk_dp);
        chk({n, "_req"}, {31'b0, imem_req}, {31'b0, q});
        if (q) chk({n, "_addr"}, 32'(imem_addr), 32'(a));
        chk({n, "_valid"}, {31'b0, valid_out}, {31'b0, v});
        if (v && chk_dp) begin
            chk({n, "_data"}, 32'(out_data), 32'(d));
            chk({n, "_pc"}, 32'(out_pc), 32'(p));
        end
    endtask

    initial begin
        tv[0]  = '{1'b1, 1'b0, 1'b0, 16'h0,  1'b0, 16'h0,    1'b0, 19'h0,   16'h0};
        tv[1]  = '{1'b1, 1'b0, 1'b0, 16'h0,  1'b1, 16'h0,    1'b0, 19'h0,   16'h0};
        tv[2]  = '{1'b1, 1'b0, 1'b0, 16'h0,  1'b1, 16'h1,    1'b0, 19'h0,   16'h0};
        tv[3]  = '{1'b1, 1'b0, 1'b0, 16'h0,  1'b1, 16'h2,    1'b1, 19'h100, 16'h0};
        tv[4]  = '{1'b1, 1'b0, 1'b0, 16'h0,  1'b1, 16'h3,    1'b1, 19'h101, 16'h1};
        tv[5]  = '{1'b1, 1'b0, 1'b0, 16'h0,  1'b1, 16'h4,    1'b1, 19'h102, 16'h2};
        tv[6]  = '{1'b1, 1'b1, 1'b0, 16'h0,  1'b0, 16'h0,    1'b1, 19'h103, 16'h3};
        tv[7]  = '{1'b1, 1'b1, 1'b0, 16'h0,  1'b0, 16'h0,    1'b1, 19'h103, 16'h3};
        tv[8]  = '{1'b1, 1'b1, 1'b0, 16'h0,  1'b0, 16'h0,    1'b1, 19'h103, 16'h3};
        tv[9]  = '{1'b1, 1'b0, 1'b0, 16'h0,  1'b0, 16'h0,    1'b1, 19'h103, 16'h3};
        tv[10] = '{1'b1, 1'b0, 1'b0, 16'h0,  1'b1, 16'h5,    1'b1, 19'h104, 16'h4};
        tv[11] = '{1'b1, 1'b0, 1'b0, 16'h0,  1'b1, 16'h6,    1'b0, 19'h0,   16'h0};
        tv[12] = '{1'b1, 1'b1, 1'b1, 16'h40, 1'b0, 16'h0,    1'b1, 19'h105, 16'h5};
        tv[13] = '{1'b1, 1'b0, 1'b0, 16'h0,  1'b1, 16'h40,   1'b0, 19'h0,   16'h0};
        tv[14] = '{1'b1, 1'b0, 1'b0, 16'h0,  1'b1, 16'h41,   1'b0, 19'h0,   16'h0};
        tv[15] = '{1'b1, 1'b0, 1'b0, 16'h0,  1'b1, 16'h42,   1'b1, 19'h140, 16'h40};

        @(negedge clk);
        chk("rst_valid", {31'b0, valid_out}, 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_pc", 32'(out_pc), 32'd0);
        cyc();
        cyc();
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            en = tv[i].en;
            stall = tv[i].st;
            redirect_valid = tv[i].rd;
            redirect_pc = tv[i].rpc;
            #1;
            see($sformatf("t%0d", i), tv[i].req, tv[i].addr, tv[i].v, tv[i].d, tv[i].p, 1'b1);
            cyc();
        end
        redirect_valid = 1'b0;
`ifdef FETCH_PERF_EN
        chk("perf_fetched_tbl", perf_fetched, 32'd6);
        chk("perf_stalls_tbl", perf_stalls, 32'd4);
`endif

        redirect_valid = 1'b1;
        redirect_pc = 16'hFFFF;
        cyc();
        redirect_valid = 1'b0;
        #1 see("wrapB", 1'b1, 16'hFFFF, 1'b0, 19'h0, 16'h0, 1'b0);
        cyc();
        #1 see("wrapC", 1'b1, 16'h0000, 1'b0, 19'h0, 16'h0, 1'b0);
        cyc();
        #1 see("wrapD", 1'b1, 16'h0001, 1'b1, 19'h100FF, 16'hFFFF, 1'b1);
        cyc();
        #1 see("wrapE", 1'b1, 16'h0002, 1'b1, 19'h00100, 16'h0000, 1'b1);
        cyc();

        en = 1'b0;
        #1 see("enF", 1'b0, 16'h0, 1'b1, 19'h101, 16'h1, 1'b1);
        cyc();
        #1 see("enG", 1'b0, 16'h0, 1'b1, 19'h102, 16'h2, 1'b1);
        cyc();
        #1 see("enH", 1'b0, 16'h0, 1'b0, 19'h0, 16'h0, 1'b0);
        cyc();
        #1 see("enI", 1'b0, 16'h0, 1'b0, 19'h0, 16'h0, 1'b0);
        cyc();

        for (int i = 0; i < 400; i++) begin
            en = $urandom_range(0, 19) != 0;
            stall = $urandom_range(0, 9) < 3;
            redirect_valid = $urandom_range(0, 29) == 0;
            redirect_pc = 16'($urandom);
            cyc();
        end
        en = 1'b0;
        stall = 1'b0;
        redirect_valid = 1'b0;
        for (int i = 0; i < 6; i++) cyc();
        chk("drain_empty", sb.size(), 32'd0);
        chk("drain_valid", {31'b0, valid_out}, 32'd0);

        en = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        chk("pre_rst_valid", {31'b0, valid_out}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("arst_valid", {31'b0, valid_out}, 32'd0);
        chk("arst_data", 32'(out_data), 32'd0);
        chk("arst_pc", 32'(out_pc), 32'd0);
        chk("arst_req", {31'b0, imem_req}, 32'd0);
`ifdef FETCH_PERF_EN
        chk("arst_perf_fetched", perf_fetched, 32'd0);
        chk("arst_perf_stalls", perf_stalls, 32'd0);
`endif
        cyc();
        cyc();
        rst = 1'b0;
        #1 see("post_rst0", 1'b0, 16'h0, 1'b0, 19'h0, 16'h0, 1'b0);
        cyc();
        #1 see("post_rst1", 1'b1, 16'h0000, 1'b0, 19'h0, 16'h0, 1'b0);
        cyc();
        cyc();
        #1 see("post_rst3", 1'b1, 16'h0002, 1'b1, 19'h100, 16'h0, 1'b1);
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction/data fetch stage that feeds the 19-bit pipeline stage directly downstream. It maintains a PC and issues reads to a synchronous memory with 1-cycle read latency. It presents each returned 19-bit word with a valid flag, and handles downstream stall (1-entry skid) and PC redirect (squash).

Parameters:
ADDR_W, 16, PC / memory address width
DATA_W, 19, fetched word width; matches downstream stage in_data
RESET_PC, 0, PC value after reset

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
en  in  1  fetch enable; 0 stops new requests
stall  in  1  downstream hold; outputs must not change while stall=1 and valid_out=1
redirect_valid  in  1  load new PC, squash in-flight/buffered words
redirect_pc  in  ADDR_W  redirect target
imem_req  out  1  read request this cycle
imem_addr  out  ADDR_W  read address (= pc)
imem_rdata  in  DATA_W  read data, valid the cycle after imem_req=1
out_data  out  DATA_W  fetched word to downstream in_data
out_pc  out  ADDR_W  address of out_data
valid_out  out  1  out_data valid; drives downstream valid_in

Behaviour:
- Reset (async, active-high): pc=RESET_PC, state=IDLE, inflight=0, skid empty, out_data=0, out_pc=0, valid_out=0. imem_req=0 while rst=1.
- FSM, 2 states:
  - IDLE: leave when en=1, go to RUN.
  - RUN: return to IDLE when en=0. A request already in flight still completes and is delivered.
- imem_req (combinational) = state==RUN & en & ~redirect_valid & ~skid_full & ~(stall & valid_out & inflight).
  - This guarantees the skid register never overflows.
- On imem_req=1:
  - pc <= pc+1, wrapping 2^ADDR_W-1 -> 0.
  - inflight <= 1 and inflight_pc <= pc.
  - If no request is issued, inflight <= 0.
- Response in cycle with inflight=1:
  - If output register is free (stall=0 or valid_out=0) and skid is empty: load out_data/out_pc, valid_out <= 1.
  - Otherwise the response goes into skid.
- When stall=0 and skid is full:
  - Output loads from skid.
  - A response arriving the same cycle goes into skid, preserving order.
- When stall=0, no skid data and no response: valid_out <= 0.
- While stall=1 and valid_out=1: out_data, out_pc and valid_out are held bit-exact.
- Latency: request at cycle t → valid_out=1 at t+2 (registered output).
- Steady state, no stall: one word per cycle.
- redirect_valid=1, highest priority (beats stall, en, in-flight response):
  - pc <= redirect_pc, inflight <= 0, skid cleared, valid_out <= 0.
  - No request is issued that cycle.
  - The first redirected request goes out the next cycle.
- en falling mid-operation: no new requests. Buffered words are still delivered in order as stall permits.
- Reset asserted mid-operation: all state returns to reset values immediately. Pending words are lost.

Optional Feature:
FETCH_PERF_EN
- Defined: adds outputs perf_fetched (32-bit, +1 per word with valid_out=1 & stall=0) and perf_stalls (32-bit, +1 per cycle with stall=1 & valid_out=1).
  - Both saturate at 2^32-1 and reset to 0.
- Undefined: these ports and counters do not exist. Functional behaviour is identical.

Decomposition:
- Shared package pipe_pkg holds:
  - DATA_W=19 constant (shared with downstream stage)
  - fetch_state_t enum {IDLE, RUN}
  - word_t typedef (DATA_W bits)
- One natural sub-module: fetch_skid_buf, a 1-entry data+pc holding register with full flag and load/unload controls.

Test Plan:
- Reset then en=1, memory model rdata=addr+0x100 → imem_addr 0,1,2…; valid_out first high 2 cycles after first imem_req with out_data=0x100, out_pc=0, then one word/cycle.
- Stall=1 for 3 cycles while out_data=0x103 → outputs held for 3 cycles; skid absorbs 0x104. After release: 0x103 consumed, then 0x104, 0x105 in order with no loss or duplicate.
- redirect_valid=1, redirect_pc=0x40 while a request is in flight and stall=1 → valid_out=0 next cycle; next imem_addr=0x40; next valid word is out_data=0x140, out_pc=0x40; squashed word never appears.
- pc=0xFFFF with ADDR_W=16 → next imem_addr=0x0000; out_pc sequence 0xFFFF, 0x0000.
- en dropped with one request in flight → that word is delivered; imem_req stays 0; valid_out falls after it is consumed.
- Async rst pulse mid-stream, between clock edges → valid_out=0 and out_data=0 immediately. After release, first imem_addr=RESET_PC. With FETCH_PERF_EN defined, counters read 0.
